// File: rtl/lcd_pixel_fetcher.sv
// Prefetches framebuffer pixels in fixed-length bursts into a small FIFO for the LCD writer.
// IDLE: wait for burst space | REQ: hold mem_req until grant | READ: collect beats | DRAIN: discard rest of burst
module lcd_pixel_fetcher #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 17
) (
  input  logic              clk_12mhz,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              data_req,
  output logic [23:0]       rgb,
  output logic              data_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [23:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              underflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0]  START_LVL = CNT_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                underflow_q, underflow_d;
  logic [23:0]         fifo_mem_q [FIFO_DEPTH];

  logic gnt_acc, flush, fifo_clr, push, pop;

  assign gnt_acc    = mem_req_q && mem_gnt;
  assign data_valid = (count_q != '0) && (state_q != DRAIN);
  assign rgb        = data_valid ? fifo_mem_q[rd_ptr_q] : 24'h0;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign underflow  = underflow_q;

  // frame_start beats both the incoming beat and any pop in the same cycle
  assign push = (state_q == READ) && mem_rvalid && !frame_start;
  assign pop  = data_req && data_valid && !frame_start;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fetch_addr_d = fetch_addr_q;
    beat_d       = beat_q;
    flush        = 1'b0;
    fifo_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          flush = 1'b1;
        end else if (count_q <= START_LVL) begin
          state_d    = REQ;
          mem_addr_d = fetch_addr_q;
        end
      end
      REQ: begin
        if (gnt_acc) begin
          mem_req_d = 1'b0;
          beat_d    = '0;
          if (frame_start) begin
            state_d  = DRAIN;
            fifo_clr = 1'b1;
          end else begin
            state_d = READ;
          end
        end else if (frame_start) begin
          flush = 1'b1;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      READ: begin
        if (mem_rvalid && (beat_q == LAST_BEAT)) begin
          if (frame_start) begin
            flush = 1'b1;
          end else begin
            state_d      = IDLE;
            fetch_addr_d = (fetch_addr_q == LAST_ADDR) ? '0 : fetch_addr_q + ADDR_STEP;
          end
        end else begin
          if (mem_rvalid) beat_d = beat_q + BEAT_W'(1);
          if (frame_start) begin
            state_d  = DRAIN;
            fifo_clr = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (mem_rvalid) begin
          if (beat_q == LAST_BEAT) flush = 1'b1;
          else                     beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d      = IDLE;
      mem_req_d    = 1'b0;
      mem_addr_d   = '0;
      fetch_addr_d = '0;
      fifo_clr     = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    if (flush) begin
      underflow_d = 1'b0;
    end else if (data_req && !data_valid && !frame_start && (state_q != DRAIN)) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fetch_addr_q <= '0;
      beat_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fetch_addr_q <= fetch_addr_d;
      beat_q       <= beat_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage needs no reset: rgb is gated by the count
  always_ff @(posedge clk_12mhz) begin
    if (push) fifo_mem_q[wr_ptr_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_lcd_pixel_fetcher.sv
// Bench for lcd_pixel_fetcher: queue-based pixel scoreboard, reactive memory model, random and directed phases.
module tb_lcd_pixel_fetcher;
  localparam int H_ACTIVE   = 8;
  localparam int V_ACTIVE   = 6;
  localparam int BURST_LEN  = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 17;
  localparam int FRAME      = H_ACTIVE * V_ACTIVE;

  logic              clk_12mhz = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic              data_req = 1'b0;
  logic [23:0]       rgb;
  logic              data_valid;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt = 1'b0;
  logic [23:0]       mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic              underflow;

  lcd_pixel_fetcher #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BURST_LEN(BURST_LEN),
    .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk_12mhz(clk_12mhz), .rst(rst), .frame_start(frame_start), .data_req(data_req),
    .rgb(rgb), .data_valid(data_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .underflow(underflow)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue plus the in-flight burst.
  logic [23:0] q[$];
  bit          burst_active, discarding, exp_uf;
  int          beats_done, burst_addr, next_addr, pix_idx;
  logic [7:0]  burst_tag;

  // Stimulus knobs and bookkeeping
  int gnt_pct, rv_pct, req_pct, blind_pct, fs_pct;
  bit rand_tag, fs_force;
  int n_bursts, n_pops, n_wraps, last_gnt_addr, second_addr;

  function automatic logic [23:0] pix(input int addr, input logic [7:0] tag);
    return {tag, 16'(addr + 1)};
  endfunction

  task automatic model_clear();
    q.delete();
    burst_active = 0;
    discarding   = 0;
    exp_uf       = 0;
    beats_done   = 0;
    next_addr    = 0;
    pix_idx      = 0;
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b0;
    frame_start = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    model_clear();
    n_bursts = 0;
    second_addr = 32'hFFFF_FFFF;
    last_gnt_addr = -1;
    repeat (hold) @(negedge clk_12mhz);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    rst = 1'b1;
  endtask

  // One clock: compare at the negedge, drive, update the model across the posedge.
  task automatic cycle();
    bit                fs, g, rv, dr;
    logic [23:0]       rd;
    logic [ADDR_W-1:0] a;
    check("data_valid", 32'(data_valid), 32'(q.size() != 0));
    check("rgb", 32'(rgb), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("underflow", 32'(underflow), 32'(exp_uf));
    if (mem_req) check("mem_addr", 32'(mem_addr), 32'(next_addr));

    fs = fs_force || ($urandom_range(999) < fs_pct);
    fs_force = 0;
    g  = mem_req && ($urandom_range(99) < gnt_pct);
    rv = burst_active && ($urandom_range(99) < rv_pct);
    rd = rv ? pix(burst_addr + beats_done, burst_tag) : 24'($urandom);
    dr = data_valid ? ($urandom_range(99) < req_pct) : ($urandom_range(99) < blind_pct);
    a  = mem_addr;
    frame_start = fs; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; data_req = dr;
    if (g) begin
      n_bursts++;
      if (n_bursts == 2) second_addr = 32'(a);
      if (a == '0 && last_gnt_addr == FRAME - BURST_LEN) n_wraps++;
      last_gnt_addr = int'(a);
    end
    if (dr && data_valid && !fs) begin
      n_pops++;
      check("pix_order", 32'(rgb[15:0]), 32'(16'(pix_idx + 1)));
      pix_idx = (pix_idx + 1) % FRAME;
    end

    @(posedge clk_12mhz);
    if (fs) begin
      q.delete();
      next_addr = 0;
      pix_idx = 0;
      if (rv) beats_done++;
      if (g) begin
        burst_active = 1;
        beats_done = 0;
        burst_addr = int'(a);
      end
      if (burst_active) discarding = 1;
      else exp_uf = 0;
    end else begin
      if (dr) begin
        if (q.size() != 0) void'(q.pop_front());
        else if (!discarding) exp_uf = 1;
      end
      if (rv) begin
        if (!discarding) begin
          check("fifo_space", 32'(q.size() < FIFO_DEPTH), 32'd1);
          q.push_back(rd);
        end
        beats_done++;
      end
      if (g) begin
        burst_active = 1;
        beats_done = 0;
        burst_addr = int'(a);
        burst_tag = rand_tag ? 8'($urandom) : 8'h00;
      end
    end
    if (burst_active && beats_done == BURST_LEN) begin
      burst_active = 0;
      if (discarding) begin
        discarding = 0;
        q.delete();
        next_addr = 0;
        exp_uf = 0;
      end else begin
        next_addr = (next_addr + BURST_LEN) % FRAME;
      end
    end
    @(negedge clk_12mhz);
  endtask

  initial begin
    bit reached;
    gnt_pct = 0; rv_pct = 100; req_pct = 0; blind_pct = 0; fs_pct = 0;
    rand_tag = 0; fs_force = 0; n_pops = 0; n_wraps = 0;
    @(negedge clk_12mhz);
    do_reset(3);

    // First request timing, first burst contents, second burst address, fill stops at 8
    cycle();
    check("req_delay_1", 32'(mem_req), 32'd0);
    cycle();
    check("req_delay_2", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'd0);
    gnt_pct = 100;
    repeat (40) cycle();
    check("burst_count", 32'(n_bursts), 32'd2);
    check("second_addr", second_addr, 32'd4);
    check("no_third_req", 32'(mem_req), 32'd0);
    check("head_pixel", 32'(rgb), 32'h000001);

    // Grant withheld: drain the 8 buffered pixels, then starve into underflow
    gnt_pct = 0; req_pct = 100; n_pops = 0;
    repeat (12) cycle();
    check("drained_pops", 32'(n_pops), 32'd8);
    blind_pct = 100;
    repeat (4) cycle();
    check("underflow_set", 32'(underflow), 32'd1);
    repeat (3) cycle();
    check("underflow_held", 32'(underflow), 32'd1);
    fs_force = 1;
    cycle();
    check("underflow_cleared", 32'(underflow), 32'd0);
    blind_pct = 0; req_pct = 0;

    // frame_start after the second beat of a burst
    gnt_pct = 100; rv_pct = 100; reached = 0;
    for (int i = 0; i < 30; i++) begin
      if (burst_active && beats_done == 2) begin
        reached = 1;
        break;
      end
      cycle();
    end
    check("beat2_reached", 32'(reached), 32'd1);
    rv_pct = 0; fs_force = 1;
    cycle();
    rv_pct = 100;
    check("drain_invalid", 32'(data_valid), 32'd0);
    reached = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin
        reached = 1;
        break;
      end
      cycle();
    end
    check("req_after_drain", 32'(reached), 32'd1);
    check("addr_after_drain", 32'(mem_addr), 32'd0);

    // Full-rate consumer with an immediately answering memory, several frame wraps
    req_pct = 100; n_wraps = 0;
    repeat (400) cycle();
    check("frame_wraps", 32'(n_wraps >= 2), 32'd1);
    check("no_underflow", 32'(underflow), 32'd0);

    // Randomized traffic with occasional blind requests and frame restarts
    gnt_pct = 50; rv_pct = 60; req_pct = 50; blind_pct = 3; fs_pct = 5; rand_tag = 1;
    repeat (3000) cycle();

    // Reset in the middle of a burst
    fs_pct = 0; reached = 0;
    for (int i = 0; i < 50; i++) begin
      if (burst_active && beats_done > 0) begin
        reached = 1;
        break;
      end
      cycle();
    end
    check("midburst_reached", 32'(reached), 32'd1);
    do_reset(2);
    fs_pct = 5;
    repeat (300) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_fetcher.md
LCD_PIXEL_FETCHER -- requirements
Module: lcd_pixel_fetcher

Interface
REQ-001 Parameter H_ACTIVE, default 480, SHALL set active pixels per line.
REQ-002 Parameter V_ACTIVE, default 272, SHALL set active lines per frame.
REQ-003 Parameter BURST_LEN, default 4, SHALL set pixels per memory burst; H_ACTIVE*V_ACTIVE SHALL be a multiple of BURST_LEN.
REQ-004 Parameter FIFO_DEPTH, default 8, SHALL set pixel FIFO entries; FIFO_DEPTH SHALL be at least BURST_LEN and a power of 2.
REQ-005 Parameter ADDR_W, default 17, SHALL set the framebuffer pixel-address width.
REQ-006 clk_12mhz  input  1  pixel clock; all logic is on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 frame_start  input  1  single-cycle pulse that restarts fetching at pixel 0.
REQ-009 data_req  input  1  pixel request from the LCD pixel writer; one pixel is consumed per high cycle.
REQ-010 rgb  output  24  FIFO head pixel, {R[23:16], G[15:8], B[7:0]}.
REQ-011 data_valid  output  1  rgb holds a valid pixel.
REQ-012 mem_req  output  1  framebuffer burst request.
REQ-013 mem_addr  output  ADDR_W  burst start pixel address.
REQ-014 mem_gnt  input  1  burst request accepted.
REQ-015 mem_rdata  input  24  read pixel data.
REQ-016 mem_rvalid  input  1  mem_rdata beat valid.
REQ-017 underflow  output  1  sticky flag: data_req arrived while data_valid was low.

Function
REQ-018 FSM states SHALL be IDLE, REQ, READ and DRAIN.
REQ-019 IDLE->REQ SHALL occur when (FIFO_DEPTH - count) >= BURST_LEN; mem_req SHALL rise on the next cycle, registered.
REQ-020 In REQ, mem_req SHALL stay high and mem_addr SHALL stay stable until mem_gnt is sampled high; then the FSM SHALL go to READ and drop mem_req.
REQ-021 In READ, each mem_rvalid SHALL push mem_rdata into the FIFO; after beat BURST_LEN the FSM SHALL return to IDLE and advance the fetch address by BURST_LEN.
REQ-022 The fetch address SHALL wrap from H_ACTIVE*V_ACTIVE-BURST_LEN to 0; for the defaults, 130556 -> 0.
REQ-023 The FIFO SHALL never overflow, because a burst starts only when space is reserved.
REQ-024 data_valid SHALL be high exactly when the FIFO is non-empty; rgb SHALL be the head entry and SHALL be 0 when empty.
REQ-025 data_req with data_valid high SHALL pop one entry; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-026 data_req with data_valid low SHALL set underflow and SHALL NOT change FIFO state.
REQ-027 frame_start in IDLE or in REQ without mem_gnt SHALL, next cycle: flush the FIFO, set address to 0, clear underflow, drop mem_req and enter IDLE.
REQ-028 frame_start in READ, or in REQ with mem_gnt high in the same cycle, SHALL enter DRAIN.
REQ-029 DRAIN SHALL discard the remaining beats of the current burst and then apply the REQ-027 actions.
REQ-030 In DRAIN, data_valid SHALL be low and pops SHALL be ignored; underflow SHALL NOT set.
REQ-031 frame_start during the final beat of READ SHALL count that beat as discarded and enter IDLE flushed.
REQ-032 frame_start and data_req in the same cycle: frame_start SHALL win; no pop and no underflow.
REQ-033 The FIFO count SHALL be log2(FIFO_DEPTH)+1 bits wide; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-034 While rst is low: state IDLE, mem_req 0, mem_addr 0, fetch address 0, FIFO empty, rgb 0, data_valid 0, underflow 0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst; beats arriving after reset releases are outside the protocol and need not be handled.
REQ-036 The first mem_req SHALL assert 2 cycles after rst deasserts, with mem_addr 0.

Verification
REQ-037 Reset release, mem_gnt on the first mem_req, 4 beats 0x000001-0x000004 -> data_valid high, rgb 0x000001; second mem_req with mem_addr 4.
REQ-038 Continuous data_req with a memory model answering every burst in 1 cycle -> rgb sequence increments, underflow stays 0 for a full frame of 130560 pixels, mem_addr wraps to 0.
REQ-039 data_req held high with mem_gnt tied 0 -> underflow set and held; frame_start clears it.
REQ-040 No data_req -> exactly 2 bursts are fetched, count reaches 8, and mem_req stays low.
REQ-041 frame_start after beat 2 of a burst -> beats 3-4 are discarded, FIFO empty, next mem_addr 0.
REQ-042 Push and pop in the same cycle at count 8, and at count 1 -> count unchanged, data order preserved.
